// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
// Shared definitions for the byte-serial memory controller and the load/store
// buffer that feeds it: FSM state encodings, the IO window base, the one-hot
// access length encodings, and a helper that turns a length into a byte count.
package mem_ctrl_pkg;

    // Addresses at or above this value are memory-mapped IO.
    localparam logic [31:0] IO_BASE_DFLT = 32'h0003_0000;

    // One-hot access length, shared with the LS buffer.
    typedef logic [2:0] len_t;
    localparam len_t LEN_B = 3'b001;
    localparam len_t LEN_H = 3'b010;
    localparam len_t LEN_W = 3'b100;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        STORE = 3'd2,
        FETCH = 3'd3,
        COOL  = 3'd4
    } state_t;

    // Byte count for a one-hot length; anything unexpected is treated as a byte.
    function automatic logic [2:0] len_bytes(input len_t len);
        logic [2:0] n;
        case (len)
            LEN_H:   n = 3'd2;
            LEN_W:   n = 3'd4;
            default: n = 3'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if
// Bundles the external byte-wide RAM/IO port and the two requester handshakes
// (load/store buffer, instruction fetch) of mem_ctrl.
//   slave  : the controller side (drives mem_a/mem_dout/mem_wr, done pulses, data)
//   master : the environment side (RAM, IO sink and the two requesters)
// Port summary:
//   mem_din/mem_dout/mem_a/mem_wr/io_buffer_full : external RAM/IO port
//   ls_sig/load_or_store/len/ls_addr/store_val    : LS request, held until ls_done
//   ls_done/ls_data                               : LS completion pulse and load data
//   if_sig/if_addr                                : fetch request, held until if_done
//   if_done/if_data                               : fetch completion pulse and word
//   clear                                         : pipeline flush
interface mem_ctrl_if;
    import mem_ctrl_pkg::*;

    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    logic        ls_sig;
    logic        load_or_store;
    len_t        len;
    logic [31:0] ls_addr;
    logic [31:0] store_val;
    logic        ls_done;
    logic [31:0] ls_data;

    logic        if_sig;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;

    logic        clear;

    modport slave (
        input  mem_din, io_buffer_full,
        input  ls_sig, load_or_store, len, ls_addr, store_val,
        input  if_sig, if_addr, clear,
        output mem_dout, mem_a, mem_wr,
        output ls_done, ls_data, if_done, if_data
    );

    modport master (
        output mem_din, io_buffer_full,
        output ls_sig, load_or_store, len, ls_addr, store_val,
        output if_sig, if_addr, clear,
        input  mem_dout, mem_a, mem_wr,
        input  ls_done, ls_data, if_done, if_data
    );

endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl
// Sole owner of the byte-wide external RAM/IO port. Arbitrates between the
// load/store buffer (priority) and instruction fetch, serialises each 1/2/4
// byte access into one byte per cycle, and returns little-endian assembled
// data with a one-cycle done pulse. Speculative loads/fetches abort on clear;
// committed stores always complete.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   rdy  : global enable; low freezes every register and suppresses mem_wr
//   bus  : mem_ctrl_if.slave (RAM port plus LS and fetch handshakes)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting; accepts LS (priority) or fetch unless clear is high
// LOAD  | issuing read addresses and capturing bytes into ls_data
// STORE | writing one byte per cycle, stalling on a full IO buffer
// FETCH | as LOAD, always 4 bytes, captured into if_data
// COOL  | one dead cycle after done so the requester can drop its sig
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [31:0] IO_BASE = IO_BASE_DFLT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    mem_ctrl_if.slave  bus
);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  nbytes_q, nbytes_d;
    logic [31:0] base_q, base_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic [31:0] ls_data_q, ls_data_d;
    logic [31:0] if_data_q, if_data_d;

    logic        ls_done_c;
    logic        if_done_c;
    logic        mem_wr_c;

    logic [2:0]  cnt_inc;
    logic [2:0]  cnt_fin;
    logic [1:0]  rd_lane;
    logic [4:0]  rd_bit;
    logic [4:0]  wr_bit;
    logic        io_stall;

    assign cnt_inc = cnt_q + 3'd1;
    // Reads: cnt counts issued addresses; byte n-1 is captured when cnt == n,
    // so the done cycle is cnt == n+1.
    assign cnt_fin = nbytes_q + 3'd1;
    // mem_din always carries the byte addressed one cycle earlier (lane cnt-1).
    assign rd_lane = cnt_q[1:0] - 2'd1;
    assign rd_bit  = {rd_lane, 3'b000};
    // Next store byte goes out together with the next address.
    assign wr_bit  = {cnt_inc[1:0], 3'b000};
    assign io_stall = (mem_a_q >= IO_BASE) && bus.io_buffer_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else if (rdy) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        nbytes_d   = nbytes_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        ls_data_d  = ls_data_q;
        if_data_d  = if_data_q;
        ls_done_c  = 1'b0;
        if_done_c  = 1'b0;
        mem_wr_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!bus.clear && bus.ls_sig) begin
                    base_d   = bus.ls_addr;
                    nbytes_d = len_bytes(bus.len);
                    cnt_d    = 3'd0;
                    mem_a_d  = bus.ls_addr;
                    if (bus.load_or_store) begin
                        wdata_d    = bus.store_val;
                        mem_dout_d = bus.store_val[7:0];
                        state_d    = STORE;
                    end else begin
                        ls_data_d = 32'd0;
                        state_d   = LOAD;
                    end
                end else if (!bus.clear && bus.if_sig) begin
                    base_d    = bus.if_addr;
                    nbytes_d  = len_bytes(LEN_W);
                    cnt_d     = 3'd0;
                    mem_a_d   = bus.if_addr;
                    if_data_d = 32'd0;
                    state_d   = FETCH;
                end
            end

            LOAD, FETCH: begin
                if (bus.clear) begin
                    cnt_d   = 3'd0;
                    state_d = IDLE;
                end else if (cnt_q == cnt_fin) begin
                    ls_done_c = (state_q == LOAD);
                    if_done_c = (state_q == FETCH);
                    cnt_d     = 3'd0;
                    state_d   = COOL;
                end else begin
                    if (cnt_q != 3'd0) begin
                        if (state_q == LOAD) begin
                            ls_data_d[rd_bit +: 8] = bus.mem_din;
                        end else begin
                            if_data_d[rd_bit +: 8] = bus.mem_din;
                        end
                    end
                    // Past the last byte the address simply holds.
                    if (cnt_inc < nbytes_q) begin
                        mem_a_d = base_q + {29'd0, cnt_inc};
                    end
                    cnt_d = cnt_inc;
                end
            end

            STORE: begin
                if (cnt_q == nbytes_q) begin
                    ls_done_c = 1'b1;
                    cnt_d     = 3'd0;
                    state_d   = COOL;
                end else if (!io_stall) begin
                    mem_wr_c = 1'b1;
                    cnt_d    = cnt_inc;
                    if (cnt_inc < nbytes_q) begin
                        mem_a_d    = base_q + {29'd0, cnt_inc};
                        mem_dout_d = wdata_q[wr_bit +: 8];
                    end
                end
            end

            COOL: begin
                state_d = IDLE;
            end

            default: begin
                cnt_d   = 3'd0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= 3'd0;
            nbytes_q   <= 3'd0;
            base_q     <= 32'd0;
            wdata_q    <= 32'd0;
            mem_a_q    <= 32'd0;
            mem_dout_q <= 8'd0;
            ls_data_q  <= 32'd0;
            if_data_q  <= 32'd0;
        end else if (rdy) begin
            cnt_q      <= cnt_d;
            nbytes_q   <= nbytes_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            ls_data_q  <= ls_data_d;
            if_data_q  <= if_data_d;
        end
    end

    // Done pulses and the write strobe are gated by rdy so a frozen cycle
    // neither writes nor completes; the pulse fires once rdy returns.
    assign bus.mem_a    = mem_a_q;
    assign bus.mem_dout = mem_dout_q;
    assign bus.mem_wr   = rdy & mem_wr_c;
    assign bus.ls_done  = rdy & ls_done_c;
    assign bus.if_done  = rdy & if_done_c;
    assign bus.ls_data  = ls_data_q;
    assign bus.if_data  = if_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;

    mem_ctrl_if bus();

    mem_ctrl #(.IO_BASE(32'h0003_0000)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int ls_cnt = 0;
    int if_cnt = 0;
    int both_cnt = 0;
    int io_writes = 0;

    logic [7:0] ram [int unsigned];

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return 8'h00;
    endfunction

    // RAM model: one-cycle read latency, stalls with the global enable.
    initial bus.mem_din = 8'h00;
    always @(posedge clk) begin
        if (rdy) bus.mem_din <= ram_rd(bus.mem_a);
        if (bus.mem_wr) begin
            ram[bus.mem_a] = bus.mem_dout;
            if (bus.mem_a >= 32'h0003_0000) io_writes++;
        end
        if (bus.ls_done) ls_cnt++;
        if (bus.if_done) if_cnt++;
        if (bus.ls_done && bus.if_done) both_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_ls(input logic st, input logic [2:0] l,
                            input logic [31:0] a, input logic [31:0] v);
        bus.ls_sig        = 1'b1;
        bus.load_or_store = st;
        bus.len           = l;
        bus.ls_addr       = a;
        bus.store_val     = v;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_chk++; if (bus.mem_a !== 32'd0) $display("FAIL rst_mem_a: got %h exp 0", bus.mem_a); else n_pass++;
        n_chk++; if (bus.mem_dout !== 8'd0) $display("FAIL rst_mem_dout: got %h exp 0", bus.mem_dout); else n_pass++;
        n_chk++; if (bus.mem_wr !== 1'b0) $display("FAIL rst_mem_wr: got %b exp 0", bus.mem_wr); else n_pass++;
        n_chk++; if (bus.ls_done !== 1'b0 || bus.if_done !== 1'b0)
            $display("FAIL rst_done: got %b%b exp 00", bus.ls_done, bus.if_done); else n_pass++;
        n_chk++; if (bus.ls_data !== 32'd0 || bus.if_data !== 32'd0)
            $display("FAIL rst_data: got %h %h exp 0 0", bus.ls_data, bus.if_data); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_lw();
        int d0 = ls_cnt;
        start_ls(1'b0, LEN_W, 32'h100, 32'd0);
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k <= 4) begin
                n_chk++; if (bus.mem_a !== 32'h100 + k - 1)
                    $display("FAIL lw_addr c%0d: got %h exp %h", k, bus.mem_a, 32'h100 + k - 1); else n_pass++;
                n_chk++; if (bus.mem_wr !== 1'b0) $display("FAIL lw_wr c%0d: got %b exp 0", k, bus.mem_wr); else n_pass++;
            end
            if (k == 5) begin
                n_chk++; if (bus.ls_done !== 1'b0) $display("FAIL lw_early_done: got %b exp 0", bus.ls_done); else n_pass++;
            end
        end
        n_chk++; if (bus.ls_done !== 1'b1) $display("FAIL lw_done c6: got %b exp 1", bus.ls_done); else n_pass++;
        n_chk++; if (bus.ls_data !== 32'h4433_2211) $display("FAIL lw_data: got %h exp 44332211", bus.ls_data); else n_pass++;
        bus.ls_sig = 1'b0;
        step();
        n_chk++; if (bus.ls_done !== 1'b0) $display("FAIL lw_pulse_width: got %b exp 0", bus.ls_done); else n_pass++;
        n_chk++; if (ls_cnt - d0 !== 1) $display("FAIL lw_done_count: got %0d exp 1", ls_cnt - d0); else n_pass++;
        step();
    endtask

    task automatic test_lb();
        start_ls(1'b0, LEN_B, 32'h102, 32'd0);
        step();
        step();
        n_chk++; if (bus.ls_done !== 1'b0) $display("FAIL lb_early_done: got %b exp 0", bus.ls_done); else n_pass++;
        step();
        n_chk++; if (bus.ls_done !== 1'b1) $display("FAIL lb_done c3: got %b exp 1", bus.ls_done); else n_pass++;
        n_chk++; if (bus.ls_data !== 32'h0000_0033) $display("FAIL lb_data: got %h exp 00000033", bus.ls_data); else n_pass++;
        bus.ls_sig = 1'b0;
        step();
        step();
    endtask

    task automatic test_sh();
        start_ls(1'b1, LEN_H, 32'h200, 32'hAABB_CCDD);
        step();
        n_chk++; if (bus.mem_wr !== 1'b1 || bus.mem_a !== 32'h200 || bus.mem_dout !== 8'hDD)
            $display("FAIL sh_byte0: got wr=%b a=%h d=%h exp 1 200 dd", bus.mem_wr, bus.mem_a, bus.mem_dout); else n_pass++;
        step();
        n_chk++; if (bus.mem_wr !== 1'b1 || bus.mem_a !== 32'h201 || bus.mem_dout !== 8'hCC)
            $display("FAIL sh_byte1: got wr=%b a=%h d=%h exp 1 201 cc", bus.mem_wr, bus.mem_a, bus.mem_dout); else n_pass++;
        step();
        n_chk++; if (bus.ls_done !== 1'b1 || bus.mem_wr !== 1'b0)
            $display("FAIL sh_done c3: got done=%b wr=%b exp 1 0", bus.ls_done, bus.mem_wr); else n_pass++;
        bus.ls_sig = 1'b0;
        step();
        n_chk++; if ({ram_rd(32'h202), ram_rd(32'h201), ram_rd(32'h200)} !== 24'h5ACCDD)
            $display("FAIL sh_ram: got %h%h%h exp 5accdd", ram_rd(32'h202), ram_rd(32'h201), ram_rd(32'h200)); else n_pass++;
        step();
    endtask

    task automatic test_priority();
        start_ls(1'b0, LEN_W, 32'h100, 32'd0);
        bus.if_sig  = 1'b1;
        bus.if_addr = 32'h300;
        step();
        n_chk++; if (bus.mem_a !== 32'h100) $display("FAIL prio_first_addr: got %h exp 100", bus.mem_a); else n_pass++;
        for (int k = 2; k <= 6; k++) step();
        n_chk++; if (bus.ls_done !== 1'b1 || bus.if_done !== 1'b0)
            $display("FAIL prio_ls_done: got ls=%b if=%b exp 1 0", bus.ls_done, bus.if_done); else n_pass++;
        n_chk++; if (bus.ls_data !== 32'h4433_2211) $display("FAIL prio_ls_data: got %h exp 44332211", bus.ls_data); else n_pass++;
        bus.ls_sig = 1'b0;
        for (int k = 7; k <= 9; k++) step();
        n_chk++; if (bus.mem_a !== 32'h300) $display("FAIL prio_fetch_addr c9: got %h exp 300", bus.mem_a); else n_pass++;
        for (int k = 10; k <= 13; k++) step();
        n_chk++; if (bus.if_done !== 1'b0) $display("FAIL prio_if_early c13: got %b exp 0", bus.if_done); else n_pass++;
        step();
        n_chk++; if (bus.if_done !== 1'b1) $display("FAIL prio_if_done c14: got %b exp 1", bus.if_done); else n_pass++;
        n_chk++; if (bus.if_data !== 32'h0010_0093) $display("FAIL prio_if_data: got %h exp 00100093", bus.if_data); else n_pass++;
        bus.if_sig = 1'b0;
        step();
        step();
    endtask

    task automatic test_clear_fetch();
        int f0 = if_cnt;
        bus.if_sig  = 1'b1;
        bus.if_addr = 32'h300;
        step();
        step();
        step();
        bus.clear  = 1'b1;
        bus.if_sig = 1'b0;
        step();
        bus.clear = 1'b0;
        n_chk++; if (bus.mem_wr !== 1'b0 || bus.if_done !== 1'b0)
            $display("FAIL clr_after: got wr=%b done=%b exp 0 0", bus.mem_wr, bus.if_done); else n_pass++;
        for (int k = 0; k < 8; k++) step();
        n_chk++; if (if_cnt - f0 !== 0) $display("FAIL clr_no_done: got %0d pulses exp 0", if_cnt - f0); else n_pass++;
        bus.if_sig  = 1'b1;
        bus.if_addr = 32'h100;
        for (int k = 1; k <= 6; k++) step();
        n_chk++; if (bus.if_done !== 1'b1) $display("FAIL clr_refetch_done: got %b exp 1", bus.if_done); else n_pass++;
        n_chk++; if (bus.if_data !== 32'h4433_2211) $display("FAIL clr_refetch_data: got %h exp 44332211", bus.if_data); else n_pass++;
        bus.if_sig = 1'b0;
        step();
        step();
    endtask

    task automatic test_clear_store();
        bus.clear = 1'b1;
        start_ls(1'b1, LEN_B, 32'h210, 32'h0000_0077);
        step();
        n_chk++; if (bus.mem_wr !== 1'b0) $display("FAIL clr_idle_block: got wr=%b exp 0", bus.mem_wr); else n_pass++;
        bus.clear = 1'b0;
        step();
        bus.clear = 1'b1;
        n_chk++; if (bus.mem_wr !== 1'b1 || bus.mem_dout !== 8'h77 || bus.mem_a !== 32'h210)
            $display("FAIL clr_store_wr: got wr=%b d=%h a=%h exp 1 77 210", bus.mem_wr, bus.mem_dout, bus.mem_a); else n_pass++;
        step();
        bus.clear = 1'b0;
        n_chk++; if (bus.ls_done !== 1'b1) $display("FAIL clr_store_done: got %b exp 1", bus.ls_done); else n_pass++;
        bus.ls_sig = 1'b0;
        step();
        n_chk++; if (ram_rd(32'h210) !== 8'h77) $display("FAIL clr_store_ram: got %h exp 77", ram_rd(32'h210)); else n_pass++;
        step();
    endtask

    task automatic test_io_stall();
        int io0 = io_writes;
        int d0  = ls_cnt;
        bus.io_buffer_full = 1'b1;
        start_ls(1'b1, LEN_B, 32'h0003_0000, 32'h0000_0041);
        for (int k = 1; k <= 4; k++) begin
            step();
            n_chk++; if (bus.mem_wr !== 1'b0) $display("FAIL io_stall_wr c%0d: got %b exp 0", k, bus.mem_wr); else n_pass++;
        end
        step();
        bus.io_buffer_full = 1'b0;
        #1;
        n_chk++; if (bus.mem_wr !== 1'b1 || bus.mem_dout !== 8'h41)
            $display("FAIL io_write c5: got wr=%b d=%h exp 1 41", bus.mem_wr, bus.mem_dout); else n_pass++;
        step();
        n_chk++; if (bus.ls_done !== 1'b1) $display("FAIL io_done c6: got %b exp 1", bus.ls_done); else n_pass++;
        bus.ls_sig = 1'b0;
        step();
        n_chk++; if (io_writes - io0 !== 1 || ram_rd(32'h0003_0000) !== 8'h41)
            $display("FAIL io_landed: got %0d writes val %h exp 1 41", io_writes - io0, ram_rd(32'h0003_0000)); else n_pass++;
        n_chk++; if (ls_cnt - d0 !== 1) $display("FAIL io_done_count: got %0d exp 1", ls_cnt - d0); else n_pass++;
        step();
    endtask

    task automatic test_rdy_lw();
        start_ls(1'b0, LEN_W, 32'h100, 32'd0);
        step();
        step();
        step();
        rdy = 1'b0;
        step();
        step();
        step();
        rdy = 1'b1;
        n_chk++; if (bus.ls_done !== 1'b0 || bus.mem_a !== 32'h102)
            $display("FAIL rdy_frozen c6: got done=%b a=%h exp 0 102", bus.ls_done, bus.mem_a); else n_pass++;
        step();
        n_chk++; if (bus.mem_a !== 32'h103) $display("FAIL rdy_resume c7: got %h exp 103", bus.mem_a); else n_pass++;
        step();
        n_chk++; if (bus.ls_done !== 1'b0) $display("FAIL rdy_early c8: got %b exp 0", bus.ls_done); else n_pass++;
        step();
        n_chk++; if (bus.ls_done !== 1'b1) $display("FAIL rdy_done c9: got %b exp 1", bus.ls_done); else n_pass++;
        n_chk++; if (bus.ls_data !== 32'h4433_2211) $display("FAIL rdy_data: got %h exp 44332211", bus.ls_data); else n_pass++;
        bus.ls_sig = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset_mid_store();
        start_ls(1'b1, LEN_W, 32'h220, 32'h1122_3344);
        step();
        n_chk++; if (bus.mem_wr !== 1'b1 || bus.mem_dout !== 8'h44)
            $display("FAIL rst_store_wr: got wr=%b d=%h exp 1 44", bus.mem_wr, bus.mem_dout); else n_pass++;
        rdy = 1'b0;
        #1;
        n_chk++; if (bus.mem_wr !== 1'b0) $display("FAIL rdy_blocks_wr: got %b exp 0", bus.mem_wr); else n_pass++;
        rdy = 1'b1;
        step();
        rst = 1'b1;
        bus.ls_sig = 1'b0;
        step();
        rst = 1'b0;
        n_chk++; if (bus.mem_a !== 32'd0 || bus.mem_dout !== 8'd0 || bus.mem_wr !== 1'b0)
            $display("FAIL rst_mid_port: got a=%h d=%h wr=%b exp 0 0 0", bus.mem_a, bus.mem_dout, bus.mem_wr); else n_pass++;
        n_chk++; if (bus.ls_data !== 32'd0 || bus.if_data !== 32'd0 || bus.ls_done !== 1'b0 || bus.if_done !== 1'b0)
            $display("FAIL rst_mid_outs: got %h %h %b %b exp all 0", bus.ls_data, bus.if_data, bus.ls_done, bus.if_done); else n_pass++;
        step();
        n_chk++; if (bus.mem_wr !== 1'b0) $display("FAIL rst_mid_idle_wr: got %b exp 0", bus.mem_wr); else n_pass++;
        start_ls(1'b0, LEN_B, 32'h101, 32'd0);
        step();
        step();
        step();
        n_chk++; if (bus.ls_done !== 1'b1 || bus.ls_data !== 32'h0000_0022)
            $display("FAIL rst_then_lb: got done=%b data=%h exp 1 00000022", bus.ls_done, bus.ls_data); else n_pass++;
        bus.ls_sig = 1'b0;
        step();
        step();
    endtask

    initial begin
        bus.io_buffer_full = 1'b0;
        bus.ls_sig         = 1'b0;
        bus.load_or_store  = 1'b0;
        bus.len            = LEN_B;
        bus.ls_addr        = 32'd0;
        bus.store_val      = 32'd0;
        bus.if_sig         = 1'b0;
        bus.if_addr        = 32'd0;
        bus.clear          = 1'b0;

        ram[32'h100] = 8'h11;
        ram[32'h101] = 8'h22;
        ram[32'h102] = 8'h33;
        ram[32'h103] = 8'h44;
        ram[32'h202] = 8'h5A;
        ram[32'h300] = 8'h93;
        ram[32'h301] = 8'h00;
        ram[32'h302] = 8'h10;
        ram[32'h303] = 8'h00;

        test_reset();
        test_lw();
        test_lb();
        test_sh();
        test_priority();
        test_clear_fetch();
        test_clear_store();
        test_io_stall();
        test_rdy_lw();
        test_reset_mid_store();

        n_chk++; if (both_cnt !== 0) $display("FAIL dual_done: got %0d cycles exp 0", both_cnt); else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
